// File: rtl/sumador_pkg.sv
// Shared types and constants for the bit-serial sign-magnitude adder/subtractor.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sumador_bit_serial.sv
// One full-adder cell with its carry flop; the carry can be preset (ld) or advanced (en).
module sumador_bit_serial
  import sumador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ld_i,
  input  logic ld_val_i,
  input  logic en_i,
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic cout_o
);

  logic c_q;

  assign s_o    = x_i ^ y_i ^ c_q;
  assign cout_o = (x_i & y_i) | (c_q & (x_i ^ y_i));

  // Preset wins over advance so a CALC->NEG handoff can reload carry=1.
  always_ff @(posedge clk) begin
    if (rst)       c_q <= 1'b0;
    else if (ld_i) c_q <= ld_val_i;
    else if (en_i) c_q <= cout_o;
  end

endmodule

// File: rtl/sumador_restador_serial.sv
// Bit-serial A+B / |A-B| unit, LSB first, one shared full-adder cell, start/busy/done handshake.
module sumador_restador_serial
  import sumador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             e
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CMAX = {CW{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             e_q, e_d;

  logic fa_x, fa_y, fa_s, fa_c;
  logic c_ld, c_ld_val, c_en;

  sumador_bit_serial u_fa (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (c_ld),
    .ld_val_i (c_ld_val),
    .en_i     (c_en),
    .x_i      (fa_x),
    .y_i      (fa_y),
    .s_o      (fa_s),
    .cout_o   (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    e_d      = e_q;
    c_ld     = 1'b0;
    c_ld_val = 1'b0;
    c_en     = 1'b0;
    // NEG negates r in place: ~r + 1 with the other adder input tied to 0.
    fa_x     = (state_q == NEG) ? ~r_q[0] : a_q[0];
    fa_y     = (state_q == NEG) ? 1'b0    : b_q[0];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = (op == OP_SUB) ? ~b : b;
          op_d     = op;
          r_d      = '0;
          cnt_d    = '0;
          c_ld     = 1'b1;
          c_ld_val = op;
          state_d  = CALC;
        end
      end
      CALC: begin
        c_en = 1'b1;
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        r_d  = {fa_s, r_q[WIDTH-1:1]};
        if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (op_q == OP_SUB && !fa_c) begin
            c_ld     = 1'b1;
            c_ld_val = 1'b1;
            state_d  = NEG;
          end else begin
            res_d   = r_d;
            e_d     = (op_q == OP_ADD) ? fa_c : 1'b0;
            state_d = DONE;
          end
        end
      end
      NEG: begin
        c_en = 1'b1;
        r_d  = {fa_s, r_q[WIDTH-1:1]};
        if (cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          res_d   = r_d;
          e_d     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      e_q     <= e_d;
    end
  end

  // Outputs only move at DONE; the working shift register is never exposed.
  assign busy   = (state_q == CALC) || (state_q == NEG);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign e      = e_q;

endmodule

// File: tb/tb_sumador_restador_serial.sv
// Bench for the serial adder/subtractor at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_sumador_restador_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic       op_s    [2];
  logic [7:0] a_s     [2];
  logic [7:0] b_s     [2];

  logic       busy4, done4, e4, busy8, done8, e8;
  logic [3:0] res4;
  logic [7:0] res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_restador_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]),
    .busy(busy4), .done(done4), .result(res4), .e(e4)
  );

  sumador_restador_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]),
    .busy(busy8), .done(done8), .result(res8), .e(e8)
  );

  function automatic logic bz(input int id); return id == 0 ? busy4 : busy8; endfunction
  function automatic logic dn(input int id); return id == 0 ? done4 : done8; endfunction
  function automatic logic ev(input int id); return id == 0 ? e4 : e8; endfunction
  function automatic logic [7:0] rs(input int id); return id == 0 ? {4'b0, res4} : res8; endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Model: per DUT, edges since capture (capture edge = 1) and the expected done edge.
  int         k [2], L [2];
  bit         act [2];
  logic [7:0] xr [2], lr [2];
  logic       xe [2], le [2];

  initial begin
    int w, mask, av, bv;
    for (int i = 0; i < 2; i++) begin act[i] = 0; lr[i] = '0; le[i] = 1'b0; end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        w    = (i == 0) ? 4 : 8;
        mask = (1 << w) - 1;
        if (rst) begin
          act[i] = 0; lr[i] = '0; le[i] = 1'b0;
        end else if (act[i]) begin
          if (k[i] == L[i]) act[i] = 0;  // DONE cycle: start ignored
          else k[i]++;
        end else if (start_s[i]) begin
          av = int'(a_s[i]) & mask;
          bv = int'(b_s[i]) & mask;
          if (!op_s[i]) begin
            xr[i] = 8'((av + bv) & mask); xe[i] = ((av + bv) >> w) != 0; L[i] = w + 1;
          end else if (av >= bv) begin
            xr[i] = 8'(av - bv); xe[i] = 1'b0; L[i] = w + 1;
          end else begin
            xr[i] = 8'(bv - av); xe[i] = 1'b1; L[i] = 2 * w + 1;
          end
          act[i] = 1; k[i] = 1;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d busy", i), 32'(bz(i)), 32'(act[i] && k[i] < L[i]));
        chk($sformatf("d%0d done", i), 32'(dn(i)), 32'(act[i] && k[i] == L[i]));
        if (act[i] && k[i] == L[i]) begin
          chk($sformatf("d%0d result", i), 32'(rs(i)), 32'(xr[i]));
          chk($sformatf("d%0d e", i), 32'(ev(i)), 32'(xe[i]));
          lr[i] = xr[i]; le[i] = xe[i];
        end else begin
          chk($sformatf("d%0d result hold", i), 32'(rs(i)), 32'(lr[i]));
          chk($sformatf("d%0d e hold", i), 32'(ev(i)), 32'(le[i]));
        end
      end
    end
  end

  // Drive one operation and wait (bounded) for done; lit=1 also checks hand-computed literals.
  task automatic run_op(input int id, input bit o, input int av, input int bv,
                        input bit lit, input int xres, input int xe_l, input int xl, input string nm);
    int n;
    bit seen;
    @(posedge clk); #1;
    start_s[id] = 1'b1; op_s[id] = o; a_s[id] = av[7:0]; b_s[id] = bv[7:0];
    @(posedge clk); #1;
    start_s[id] = 1'b0;
    n = 1; seen = 0;
    for (int t = 0; t < 80 && !seen; t++) begin
      @(negedge clk);
      if (dn(id)) seen = 1;
      else begin @(posedge clk); n++; end
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    if (lit) begin
      chk({nm, " latency"}, 32'(n), 32'(xl));
      chk({nm, " result"}, 32'(rs(id)), 32'(xres));
      chk({nm, " e"}, 32'(ev(id)), 32'(xe_l));
    end
  endtask

  initial begin
    int ndone, rres, re;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin start_s[i] = 0; op_s[i] = 0; a_s[i] = '0; b_s[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy4", 32'(busy4), 0);
    chk("reset done4", 32'(done4), 0);
    chk("reset res4", 32'(res4), 0);
    chk("reset e8", 32'(e8), 0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(0, 0, 5, 3, 1, 8, 0, 5, "add 5+3");
    run_op(0, 0, 9, 9, 1, 2, 1, 5, "add 9+9 ovf");
    run_op(0, 1, 7, 2, 1, 5, 0, 5, "sub 7-2");
    run_op(0, 1, 3, 5, 1, 2, 1, 9, "sub 3-5 neg");
    run_op(0, 1, 6, 6, 1, 0, 0, 5, "sub 6-6");
    run_op(0, 0, 15, 15, 1, 14, 1, 5, "add 15+15");

    // start re-pulsed while busy must be ignored
    @(posedge clk); #1; start_s[0] = 1; op_s[0] = 1; a_s[0] = 8'd3; b_s[0] = 8'd5;
    @(posedge clk); #1; start_s[0] = 0;
    @(posedge clk); @(posedge clk); #1; start_s[0] = 1; op_s[0] = 0; a_s[0] = 8'd1; b_s[0] = 8'd1;
    @(posedge clk); #1; start_s[0] = 0;
    ndone = 0; rres = -1; re = -1;
    repeat (14) begin
      @(negedge clk);
      if (done4) begin ndone++; rres = int'(res4); re = int'(e4); end
    end
    chk("repulse done count", 32'(ndone), 1);
    chk("repulse result", 32'(rres), 2);
    chk("repulse e", 32'(re), 1);

    // reset in the middle of the NEG pass
    @(posedge clk); #1; start_s[0] = 1; op_s[0] = 1; a_s[0] = 8'd0; b_s[0] = 8'd15;
    @(posedge clk); #1; start_s[0] = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst-in-NEG busy", 32'(busy4), 0);
    chk("rst-in-NEG result", 32'(res4), 0);
    chk("rst-in-NEG e", 32'(e4), 0);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done4) ndone++; end
    chk("rst-in-NEG no done", 32'(ndone), 0);
    run_op(0, 1, 15, 0, 1, 15, 0, 5, "sub 15-0 after rst");

    run_op(1, 0, 200, 100, 1, 44, 1, 9, "w8 add 200+100");
    run_op(1, 1, 10, 250, 1, 240, 1, 17, "w8 sub 10-250");
    run_op(1, 1, 250, 10, 1, 240, 0, 9, "w8 sub 250-10");
    run_op(1, 1, 128, 128, 1, 0, 0, 9, "w8 sub 128-128");

    for (int t = 0; t < 1000; t++)
      run_op(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 0, 0, 0, 0, "w8 random");

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_restador_serial.md
Name: sumador_restador_serial

Overview:
- Parametrised, bit-serial sign-magnitude adder/subtractor: WIDTH-bit unsigned operands, one full-adder cell reused once per bit, LSB first.
- op=0 computes A+B with carry-out; op=1 computes |A-B| with a sign flag. A negative difference gets a second serial pass for two's-complement correction.
- Replaces the fixed 4-bit combinational add/sub in the lab datapath where area matters more than latency; start/busy/done handshake.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract (A-B).
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high from the capture edge until done is asserted.
- done  output  1  one-cycle pulse: result/e valid.
- result  output  WIDTH  sum (mod 2^WIDTH) or |A-B|.
- e  output  1  add: carry-out; sub: 1 when A<B (negative), else 0.

Behaviour:
- Single clock, synchronous active-high reset. On rst: state=IDLE; busy, done, e = 0; result = 0; internal operand/carry registers = 0. Reset mid-operation aborts without a done pulse.
- States: IDLE, CALC, NEG, DONE.
- IDLE: on start=1, capture a, b and op into shift registers and clear the bit counter.
  - Carry flop = op; B bits are inverted when op=1 (A + ~B + 1).
  - busy=1 from the next cycle. Go to CALC.
- CALC: each cycle, one bit goes through the full adder: sum bit shifts into the MSB of the result shift register, carry flop updates. Runs exactly WIDTH cycles. After the last bit:
  - op=0: e = final carry; go to DONE.
  - op=1, final carry=1 (A>=B): e=0; go to DONE.
  - op=1, final carry=0 (A<B): e=1; reload carry flop=1; go to NEG.
- NEG: WIDTH cycles. Serial two's complement of the result register: ~r + 1 through the same full-adder cell with the other input 0. Then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle. Go to IDLE.
- Latency, counted in edges after the capture edge: done high after WIDTH+1 edges (add, or sub with A>=B); after 2*WIDTH+1 edges (sub with A<B).
- result and e are stable and hold from DONE until the next capture edge. They do not change during CALC/NEG until DONE; a separate shift register feeds the output register.
- start while busy=1 or in DONE is ignored, not queued. start in the same cycle as rst: reset wins.
- A==B with op=1: result=0, e=0, no NEG pass.
- Add overflow: result = (A+B) mod 2^WIDTH, e=1.
- Bit counter is $clog2(WIDTH+1) bits wide and saturates safely; it has no wrap behaviour visible at the ports.

Decomposition:
- Package sumador_pkg holds the state enum (IDLE, CALC, NEG, DONE) and localparam OP_ADD=0, OP_SUB=1.
- Sub-module sumador_bit_serial: one full adder plus a carry flip-flop with load/enable inputs. It is instantiated once and shared by CALC and NEG through an input mux. All control stays in the top FSM.

Test Plan:
- WIDTH=4, a=5, b=3, op=0, start pulse → done after 5 edges; result=8, e=0; busy high for 4 cycles.
- WIDTH=4, a=9, b=9, op=0 → result=2, e=1 (overflow), latency 5.
- WIDTH=4, a=7, b=2, op=1 → result=5, e=0, latency 5. Then a=3, b=5, op=1 → result=2, e=1, latency 9. Check NEG is entered only in the second case.
- WIDTH=4, a=6, b=6, op=1 → result=0, e=0, latency 5.
- Re-pulse start (a=1, b=1) two cycles into a busy op → ignored; the original result is delivered and exactly one done pulse occurs.
- Assert rst during NEG (a=0, b=15, op=1) → next cycle busy=0, result=0, e=0, no done. Then a fresh start (a=15, b=0, op=1) → result=15, e=0.
- Repeat the add/sub cases at WIDTH=8 against a reference model over 1000 random operand pairs, checking latency and values.
